// File: rtl/display_pkg.sv
// Shared constants for the four-digit seven-segment scan controller.
// State encoding and active-low segment table (seg[0]=a .. seg[6]=g).
package display_pkg;

  localparam int DIGITS = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Entry n is the pattern for hex digit n; a 0 bit lights the segment.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, // F
    7'h06, // E
    7'h21, // d
    7'h46, // C
    7'h03, // b
    7'h08, // A
    7'h10, // 9
    7'h00, // 8
    7'h78, // 7
    7'h02, // 6
    7'h12, // 5
    7'h19, // 4
    7'h30, // 3
    7'h24, // 2
    7'h79, // 1
    7'h40  // 0
  };

endpackage

// File: rtl/display_scan_controller_seg7_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational table lookup.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[nib];

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller with frame-boundary buffering.
// Optional DISPLAY_SCAN_BLINK_EN adds a blink input and frame counter.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic        blink,
`endif
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [2:0]  load_ndigits,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [15:0]   r_act_val;
  logic [2:0]    r_act_nd;
  logic [15:0]   r_sh_val;
  logic [2:0]    r_sh_nd;
  logic          r_pending;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_xfer;
  logic          w_idle_ld;
  logic          w_tick;
  logic          w_bound;
  logic [2:0]    w_ld_nd;
  logic          w_upd;
  logic [1:0]    w_nidx;
  logic [15:0]   w_nval;
  logic [2:0]    w_nnd;
  logic [3:0]    w_nib;
  logic [6:0]    w_dseg;
  logic          w_on;

  assign load_ready = !r_pending;
  assign w_xfer     = load_valid && load_ready;
  assign w_idle_ld  = (r_state == ST_IDLE) && w_xfer;
  assign w_tick     = (r_state == ST_SCAN) && (r_pre == PMAX);
  assign w_bound    = w_tick && (r_idx == 2'd3);
  assign frame_done = w_bound;
  assign w_ld_nd    = (load_ndigits > 3'd4) ? 3'd4 : load_ndigits;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: the first accepted load starts scanning for good.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_xfer) w_state_nxt = ST_SCAN;
      ST_SCAN: w_state_nxt = ST_SCAN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Select the digit, value and count to drive after this edge.
  always_comb begin
    w_upd  = 1'b0;
    w_nidx = r_idx;
    w_nval = r_act_val;
    w_nnd  = r_act_nd;
    unique case (1'b1)
      w_idle_ld: begin
        w_upd  = 1'b1;
        w_nidx = 2'd0;
        w_nval = load_value;
        w_nnd  = w_ld_nd;
      end
      w_tick: begin
        w_upd  = 1'b1;
        w_nidx = r_idx + 2'd1;
        if (w_bound && r_pending) begin
          w_nval = r_sh_val;
          w_nnd  = r_sh_nd;
        end
      end
      default: ;
    endcase
  end

  assign w_nib = w_nval[{w_nidx, 2'b00} +: 4];
  assign w_on  = {1'b0, w_nidx} < w_nnd;

  seg7_decode u_dec (
    .nib (w_nib),
    .seg (w_dseg)
  );

  // Prescaler, digit index and registered digit drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= 2'd0;
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      if (r_state == ST_SCAN) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      else                    r_pre <= '0;
      if (w_upd) begin
        r_idx <= w_nidx;
        r_an  <= w_on ? ~(4'b0001 << w_nidx) : 4'hF;
        r_seg <= w_on ? w_dseg : 7'h7F;
      end
    end
  end

  // Active/shadow buffers; shadow is promoted only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_val <= '0;
      r_act_nd  <= '0;
      r_sh_val  <= '0;
      r_sh_nd   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_idle_ld) begin
        r_act_val <= load_value;
        r_act_nd  <= w_ld_nd;
      end else if (w_bound && r_pending) begin
        r_act_val <= r_sh_val;
        r_act_nd  <= r_sh_nd;
        r_pending <= 1'b0;
      end
      if ((r_state == ST_SCAN) && w_xfer) begin
        r_sh_val  <= load_value;
        r_sh_nd   <= w_ld_nd;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  logic [4:0] r_fcnt;

  // Frame counter; its top bit gates the anodes while blinking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_fcnt <= '0;
    else if (w_bound) r_fcnt <= r_fcnt + 5'd1;
  end

  assign an  = (blink && r_fcnt[4]) ? 4'hF : r_an;
`else
  assign an  = r_an;
`endif
  assign seg = r_seg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller at CLK_DIV=4.
// Checks reset, scan order, clamp, buffered loads and async reset.
module tb_display_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        blink;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [2:0]  load_ndigits;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int n_chk;
  int n_fail;
  int fd_n;

  display_scan_controller #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef DISPLAY_SCAN_BLINK_EN
    .blink        (blink),
`endif
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_value   (load_value),
    .load_ndigits (load_ndigits),
    .an           (an),
    .seg          (seg),
    .frame_done   (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("fd_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic digit(input string tag,
                       input logic [3:0] ea,
                       input logic [6:0] es);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    blink        = 1'b0;
    load_valid   = 1'b0;
    load_value   = '0;
    load_ndigits = '0;

    #12;
    digit("rst", 4'hF, 7'h7F);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    digit("idle", 4'hF, 7'h7F);

    load_value   = 16'h12AF;
    load_ndigits = 3'd4;
    load_valid   = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    digit("f1_d0", 4'b1110, 7'h0E);
    chk("f1_ready", 32'(load_ready), 32'd1);
    cyc(4);
    digit("f1_d1", 4'b1101, 7'h08);
    cyc(4);
    digit("f1_d2", 4'b1011, 7'h24);
    cyc(4);
    digit("f1_d3", 4'b0111, 7'h79);
    chk("f1_fd_early", 32'(frame_done), 32'd0);
    cyc(2);
    chk("f1_fd_pre", 32'(frame_done), 32'd0);
    cyc(1);
    chk("f1_fd", 32'(frame_done), 32'd1);
    cyc(1);
    chk("f1_fd_end", 32'(frame_done), 32'd0);
    digit("f2_d0", 4'b1110, 7'h0E);

    load_value   = 16'h0042;
    load_ndigits = 3'd2;
    load_valid   = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    chk("nd2_ready", 32'(load_ready), 32'd0);
    digit("nd2_old", 4'b1110, 7'h0E);
    wait_fd(fd_n);
    digit("nd2_old_d3", 4'b0111, 7'h79);
    cyc(1);
    digit("nd2_d0", 4'b1110, 7'h24);
    chk("nd2_ready_back", 32'(load_ready), 32'd1);
    cyc(4);
    digit("nd2_d1", 4'b1101, 7'h19);
    cyc(4);
    digit("nd2_d2", 4'b1111, 7'h7F);

    load_value   = 16'h3333;
    load_ndigits = 3'd4;
    load_valid   = 1'b1;
    cyc(1);
    chk("p3_ready", 32'(load_ready), 32'd0);
    load_value   = 16'h5678;
    load_ndigits = 3'd7;
    wait_fd(fd_n);
    digit("p3_old_d3", 4'b1111, 7'h7F);
    chk("p3_stall", 32'(load_ready), 32'd0);
    cyc(1);
    digit("p3_d0", 4'b1110, 7'h30);
    chk("p3_ready_back", 32'(load_ready), 32'd1);
    cyc(1);
    chk("p5_taken", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    cyc(3);
    digit("p3_d1", 4'b1101, 7'h30);
    wait_fd(fd_n);
    cyc(1);
    digit("c7_d0", 4'b1110, 7'h00);
    cyc(4);
    digit("c7_d1", 4'b1101, 7'h78);
    cyc(4);
    digit("c7_d2", 4'b1011, 7'h02);
    cyc(4);
    digit("c7_d3", 4'b0111, 7'h12);

    #3;
    rst_n = 1'b0;
    #1;
    digit("arst", 4'hF, 7'h7F);
    chk("arst_ready", 32'(load_ready), 32'd1);
    chk("arst_fd", 32'(frame_done), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    digit("arst_idle", 4'hF, 7'h7F);

    load_value   = 16'hFFFF;
    load_ndigits = 3'd0;
    load_valid   = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    digit("nd0_d0", 4'hF, 7'h7F);
    wait_fd(fd_n);
    chk("nd0_frame_len", 32'(fd_n), 32'd15);
    digit("nd0_d3", 4'hF, 7'h7F);
    cyc(1);
    digit("nd0_next", 4'hF, 7'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
